// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
  localparam int unsigned WORD_BYTES          = 4;
  localparam int unsigned PC_INCREMENT        = 4;
  localparam int unsigned BUF_DEPTH           = 2;

  localparam logic [DEFAULT_ADDR_WIDTH-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [DEFAULT_INSTR_WIDTH-1:0] NOP_WORD         = 32'h0000_0000;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {pc+4, instruction} pairs for decode.
module fetch_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = BUF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  entry_t     entry_in,
  output entry_t     entry_out,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  entry_t     store [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_pop;
  logic       do_push;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != FULL_COUNT) || do_pop);
  assign entry_out = store[rd_ptr];

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // NOTE: storage is not reset; the top gates the head to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= entry_in;
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, reads combinational instruction memory and buffers results for decode.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned           BUF_DEPTH   = instruction_fetch_stage_pkg::BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic                   fetch_stalled
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instruction;
  } entry_t;

  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next_seq;
  logic [1:0]            count;
  logic                  pop;
  logic                  push;
  entry_t                head;
  entry_t                fetched;
  logic                  unused_branch_lsbs;

  assign unused_branch_lsbs = ^branch_addr[1:0];
  assign pc_next_seq        = pc_reg + ADDR_WIDTH'(PC_INCREMENT);
  assign imem_addr          = pc_reg;

  assign out_valid     = (count != 2'd0);
  assign pop           = out_valid && out_ready;
  assign push          = !branch_taken && ((count != FULL_COUNT) || pop);
  assign fetch_stalled = !branch_taken && (count == FULL_COUNT) && !pop;

  assign fetched.pc          = pc_next_seq;
  assign fetched.instruction = imem_instruction;

  // Empty buffer presents zeros so decode never sees stale storage.
  assign out_pc          = out_valid ? head.pc : '0;
  assign out_instruction = out_valid ? head.instruction : INSTR_WIDTH'(NOP_WORD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (branch_taken) begin
      pc_reg <= {branch_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_reg <= pc_next_seq;
    end
  end

  fetch_buffer #(
    .entry_t (entry_t),
    .DEPTH   (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (branch_taken),
    .entry_in  (fetched),
    .entry_out (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench with a reference queue model of the fetch buffer and a second instance for PC wrap.
module tb_instruction_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        fetch_stalled;

  logic [31:0] imem_addr_w;
  logic [31:0] imem_instruction_w;
  logic        out_valid_w;
  logic [31:0] out_pc_w;
  logic [31:0] out_instruction_w;
  logic        fetch_stalled_w;

  int          n_cmp;
  int          n_err;
  sb_t         q[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_0014;
      32'h0000_0004: return 32'hE3A0_1A01;
      default:       return {4'hE, a[27:0]} ^ 32'h0550_0000;
    endcase
  endfunction

  assign imem_instruction   = mem_word(imem_addr);
  assign imem_instruction_w = mem_word(imem_addr_w);

  instruction_fetch_stage u_dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction),
    .fetch_stalled    (fetch_stalled)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr_w),
    .imem_instruction (imem_instruction_w),
    .branch_taken     (1'b0),
    .branch_addr      (32'h0),
    .out_valid        (out_valid_w),
    .out_ready        (1'b1),
    .out_pc           (out_pc_w),
    .out_instruction  (out_instruction_w),
    .fetch_stalled    (fetch_stalled_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output against the reference queue with the current inputs applied.
  task automatic verify();
    logic        v;
    logic        p;
    sb_t         h;
    v = (q.size() != 0);
    h = v ? q[0] : '0;
    p = v && out_ready;
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, v});
    check("out_pc", out_pc, h.pc);
    check("out_instruction", out_instruction, h.ins);
    check("fetch_stalled", {31'b0, fetch_stalled},
          {31'b0, !branch_taken && (q.size() == 2) && !p});
  endtask

  task automatic advance_model();
    sb_t e;
    if (branch_taken) begin
      q.delete();
      m_pc = {branch_addr[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (q.size() < 2) begin
        e.pc  = m_pc + 32'd4;
        e.ins = mem_word(m_pc);
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick(input logic bt, input logic [31:0] ba, input logic rdy);
    branch_taken = bt;
    branch_addr  = ba;
    out_ready    = rdy;
    #4;
    verify();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    out_ready    = 1'b1;
    m_pc         = 32'h0;
    @(posedge clk);
    #1;

    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_instr", out_instruction, 32'h0);
    check("reset_stall", {31'b0, fetch_stalled}, 32'd0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("wrap_reset_addr", imem_addr_w, 32'hFFFF_FFFC);
    rst = 1'b1;

    tick(1'b0, 32'h0, 1'b1);
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'h4);
    check("first_instr", out_instruction, 32'hE3A0_0014);
    check("wrap_first_pc", out_pc_w, 32'h0);
    check("wrap_first_instr", out_instruction_w, mem_word(32'hFFFF_FFFC));
    check("wrap_next_addr", imem_addr_w, 32'h0);

    tick(1'b0, 32'h0, 1'b1);
    check("second_pc", out_pc, 32'h8);
    check("second_instr", out_instruction, 32'hE3A0_1A01);

    for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b0);
    check("stall_addr", imem_addr, 32'hC);
    check("stall_head", out_pc, 32'h8);
    check("stall_flag", {31'b0, fetch_stalled}, 32'd1);

    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1);

    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h3C, 1'b0);
    check("redirect_valid", {31'b0, out_valid}, 32'd0);
    check("redirect_addr", imem_addr, 32'h3C);
    tick(1'b0, 32'h0, 1'b1);
    check("target_pc", out_pc, 32'h40);
    check("target_instr", out_instruction, mem_word(32'h3C));

    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h3E, 1'b1);
    check("unaligned_addr", imem_addr, 32'h3C);
    tick(1'b0, 32'h0, 1'b1);
    check("unaligned_target_pc", out_pc, 32'h40);

    tick(1'b1, 32'h100, 1'b1);
    tick(1'b1, 32'h200, 1'b1);
    check("held_branch_valid", {31'b0, out_valid}, 32'd0);
    tick(1'b0, 32'h0, 1'b1);
    check("held_branch_pc", out_pc, 32'h204);

    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check("midreset_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_pc", out_pc, 32'h0);
    check("midreset_addr", imem_addr, 32'h0);
    q.delete();
    m_pc = 32'h0;
    rst  = 1'b1;

    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1);
    check("resume_pc", out_pc, 32'hC);
    verify();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Requester side of the instruction memory: owns the PC, drives the word address into the combinational-read instruction memory and captures the returned word.
- Hands {PC+4, instruction} to the decode stage through a 2-entry valid/ready buffer.
- Accepts branch redirects from execute. Sits between instruction memory and ID pipeline register.

Parameters:
- ADDR_WIDTH, 32, PC/address width in bits
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- BUF_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory (= pc_reg, combinational)
- imem_instruction  input  INSTR_WIDTH  word returned same cycle for imem_addr
- branch_taken  input  1  redirect request from execute
- branch_addr  input  ADDR_WIDTH  redirect target
- out_valid  output  1  buffer head holds a fetched instruction
- out_ready  input  1  decode accepts head this cycle
- out_pc  output  ADDR_WIDTH  address of head instruction + 4
- out_instruction  output  INSTR_WIDTH  head instruction word
- fetch_stalled  output  1  status: fetch suppressed this cycle because the buffer is full and not popped

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): pc_reg=RESET_PC, buffer count=0, out_valid=0, out_pc=0, out_instruction=0, fetch_stalled=0. Outputs are zero whenever the buffer is empty.
- pop = out_valid & out_ready.
- push = !branch_taken & (count<2 | pop).
- On push at edge: enqueue {pc_reg+4, imem_instruction}; pc_reg <= pc_reg+4 (mod 2^ADDR_WIDTH, wraps silently).
- No push: pc_reg holds and imem_addr is stable.
- Latency: a word presented on imem_addr in cycle N appears at the buffer head in cycle N+1 if the buffer was empty or drained. No combinational bypass from imem_instruction to outputs.
- Throughput: 1 instruction/cycle with out_ready held high. Count stays at 1 (push and pop in the same edge).
- Full (count=2) & out_ready=0: no push, pc_reg held, fetch_stalled=1. Contents and order preserved; no loss, no duplication.
- Full & out_ready=1: pop and push in the same edge; count stays 2.
- Empty & out_ready=1: no pop; out_ready is ignored when out_valid=0.
- branch_taken=1 at edge: buffer cleared (count=0), pc_reg <= {branch_addr[ADDR_WIDTH-1:2],2'b00}, no push that cycle.
  - Any simultaneous pop is discarded with the rest of the buffer; decode flushes its own register.
  - out_valid=0 in the next cycle. The target instruction appears one cycle later.
- branch_addr[1:0] is ignored (forced word alignment).
- branch_taken held high for multiple cycles: each edge reloads the PC, and nothing is fetched until it drops.
- Reset asserted mid-stream: everything returns to reset values immediately. After release, the first push occurs at the first rising edge.
- fetch_stalled = !branch_taken & (count==2) & !pop, combinational.

Decomposition:
- Shared package:
  - WORD_BYTES=4, PC_INCREMENT=4.
  - typedef fetch_entry_t {pc[ADDR_WIDTH], instruction[INSTR_WIDTH]}.
  - Reset constants RESET_PC default and NOP_WORD=0 for empty output.
- Sub-module fetch_buffer: 2-entry synchronous FIFO.
  - Ports: push, pop, clear, entry in/out, count.
  - Same clk and active-low asynchronous rst.
- Top-level: PC register, push/stall/redirect logic, address alignment.

Test Plan:
- Reset release, mem[0]=32'hE3A00014, mem[4]=32'hE3A01A01, out_ready=1 → edge 1: out_valid=1, out_pc=4, out_instruction=E3A00014. Edge 2: out_pc=8, E3A01A01. imem_addr then 8, 12, ... one per cycle.
- out_ready=0 for 5 cycles after the first fetch → count reaches 2, imem_addr frozen at 8, fetch_stalled=1, head stays pc=4. Raise out_ready → consecutive out_pc 4, 8, 12, with no gap after the first pop, no duplicate, no skip.
- Buffer full, branch_taken=1, branch_addr=32'h3C → next cycle out_valid=0, imem_addr=3C. Following cycle out_pc=40, out_instruction=mem[3C].
- branch_addr=32'h3E with simultaneous pop → treated as 3C; popped entry dropped; out_pc=40 two cycles later.
- rst driven low between clock edges with the buffer holding 2 entries → out_valid=0, out_pc=0, imem_addr=RESET_PC before the next edge. Release → fetch resumes at RESET_PC.
- RESET_PC=32'hFFFF_FFFC → first out_pc=32'h0000_0000, next imem_addr=0 (wrap).
